// File: rtl/tff_ctrl_pkg.sv
// Shared types for the T flip-flop modulo counter controller.
// State encoding and width limits used by the controller.
package tff_ctrl_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low clear.
// Toggles q on a clock edge when t is high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Programmable modulo up/down counter built from a T flip-flop bank.
// The FSM chooses the toggle vector that moves the bank each cycle.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             up,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    state_t           state;
    state_t           state_nx;
    logic             dir_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] mod_m1;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             wrap;
    logic             cnt;
    logic             load;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (t[i]),
            .q     (q[i]),
            .q_bar (qb[i])
        );
    end

    // mod_r of 0 wraps to all ones, giving the full binary range
    assign mod_m1 = mod_r - WIDTH'(1);
    assign init   = dir_r ? '0 : mod_m1;
    assign wrap   = dir_r ? (q == mod_m1) : (q == '0);
    assign load   = (state == IDLE) && start && !stop;

    always_comb begin
        logic cu;
        logic cd;
        cu = 1'b1;
        cd = 1'b1;
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = cu;
            dn_t[i] = cd;
            cu = cu & q[i];
            cd = cd & qb[i];
        end
    end

    always_comb begin
        state_nx = state;
        t        = '0;
        cnt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) state_nx = CLEAR;
            end
            CLEAR: begin
                t        = q ^ init;
                state_nx = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (hold) begin
                    state_nx = PAUSE;
                end else begin
                    cnt = 1'b1;
                    if (wrap) t = dir_r ? q : (q ^ mod_m1);
                    else      t = dir_r ? up_t : dn_t;
                end
            end
            PAUSE: begin
                if (stop)       state_nx = IDLE;
                else if (!hold) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            tc    <= 1'b0;
            dir_r <= 1'b1;
            mod_r <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            tc    <= cnt & wrap;
            if (load) begin
                dir_r <= up;
                mod_r <= modulus;
            end
        end
    end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: fixed vector table, corner sequences
// and random traffic against an arithmetic counter model.
module tb_tff_counter_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         hold;
    logic         up;
    logic [W-1:0] modulus;
    logic [W-1:0] q;
    logic         busy;
    logic         tc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tff_counter_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .hold    (hold),
        .up      (up),
        .modulus (modulus),
        .q       (q),
        .busy    (busy),
        .tc      (tc)
    );

    typedef enum {M_IDLE, M_LOAD, M_COUNT, M_FROZEN} mphase_t;

    mphase_t ph;
    int      m_q;
    bit      m_dir;
    int      m_mod;
    bit      m_busy;
    bit      m_tc;

    typedef struct {
        logic         s;
        logic         p;
        logic         h;
        logic         u;
        logic [W-1:0] m;
        logic [W-1:0] eq;
        logic         eb;
        logic         et;
    } vec_t;

    vec_t tbl[$];

    function automatic int span();
        return (m_mod == 0) ? (1 << W) : m_mod;
    endfunction

    task automatic model_reset();
        ph     = M_IDLE;
        m_q    = 0;
        m_dir  = 1'b1;
        m_mod  = 0;
        m_busy = 1'b0;
        m_tc   = 1'b0;
    endtask

    task automatic model_step();
        m_tc = 1'b0;
        case (ph)
            M_IDLE: begin
                if (start && !stop) begin
                    m_dir = up;
                    m_mod = int'(modulus);
                    ph    = M_LOAD;
                end
            end
            M_LOAD: begin
                m_q = m_dir ? 0 : span() - 1;
                ph  = stop ? M_IDLE : M_COUNT;
            end
            M_COUNT: begin
                if (stop) ph = M_IDLE;
                else if (hold) ph = M_FROZEN;
                else if (m_dir) begin
                    if (m_q == span() - 1) begin
                        m_q  = 0;
                        m_tc = 1'b1;
                    end else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin
                        m_q  = span() - 1;
                        m_tc = 1'b1;
                    end else m_q = m_q - 1;
                end
            end
            M_FROZEN: begin
                if (stop) ph = M_IDLE;
                else if (!hold) ph = M_COUNT;
            end
            default: ph = M_IDLE;
        endcase
        m_busy = (ph != M_IDLE);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(bit s, bit p, bit h, bit u, int m);
        start   = s;
        stop    = p;
        hold    = h;
        up      = u;
        modulus = W'(m);
    endtask

    task automatic step(string nm);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check({nm, "_q"}, 32'(q), 32'(m_q));
        check({nm, "_busy"}, 32'(busy), 32'(m_busy));
        check({nm, "_tc"}, 32'(tc), 32'(m_tc));
    endtask

    task automatic add(bit s, bit p, bit h, bit u, int m,
                       int eq, bit eb, bit et);
        vec_t v;
        v.s  = s;
        v.p  = p;
        v.h  = h;
        v.u  = u;
        v.m  = W'(m);
        v.eq = W'(eq);
        v.eb = eb;
        v.et = et;
        tbl.push_back(v);
    endtask

    initial begin
        // up count modulo 6
        add(1, 0, 0, 1, 6, 0, 1, 0);
        add(0, 0, 0, 1, 6, 0, 1, 0);
        for (int k = 1; k <= 5; k++) add(0, 0, 0, 1, 6, k, 1, 0);
        add(0, 0, 0, 0, 9, 0, 1, 1);
        add(0, 0, 0, 0, 9, 1, 1, 0);
        add(0, 1, 0, 1, 6, 1, 0, 0);
        // full-range down count
        add(1, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 5, 15, 1, 0);
        for (int k = 14; k >= 0; k--) add(0, 0, 0, 1, 5, k, 1, 0);
        add(0, 0, 0, 1, 5, 15, 1, 1);
        add(0, 0, 0, 1, 5, 14, 1, 0);

        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_q", 32'(q), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tc", 32'(tc), 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].p, tbl[i].h, tbl[i].u, int'(tbl[i].m));
            @(posedge clk);
            model_step();
            @(negedge clk);
            check($sformatf("tbl_q[%0d]", i), 32'(q), 32'(tbl[i].eq));
            check($sformatf("tbl_busy[%0d]", i), 32'(busy), 32'(tbl[i].eb));
            check($sformatf("tbl_tc[%0d]", i), 32'(tc), 32'(tbl[i].et));
        end

        // hold at 7 with modulus 10
        drive(0, 1, 0, 1, 10);
        step("h_stop");
        drive(1, 0, 0, 1, 10);
        step("h_start");
        drive(0, 0, 0, 1, 10);
        for (int k = 0; k < 8; k++) step("h_cnt");
        check("h_at7", 32'(q), 7);
        drive(0, 0, 1, 1, 10);
        for (int k = 0; k < 3; k++) begin
            step("h_hold");
            check("h_frozen", 32'(q), 7);
        end
        drive(0, 0, 0, 1, 10);
        step("h_resume");
        check("h_resume_edge", 32'(q), 7);
        step("h_next");
        check("h_after", 32'(q), 8);

        // stop beats start and hold
        drive(0, 1, 0, 1, 10);
        step("s_stop");
        drive(1, 0, 0, 1, 10);
        step("s_start");
        drive(0, 0, 0, 1, 10);
        for (int k = 0; k < 5; k++) step("s_cnt");
        check("s_at4", 32'(q), 4);
        drive(1, 1, 1, 1, 10);
        step("s_all");
        check("s_frozen_q", 32'(q), 4);
        check("s_idle_busy", 32'(busy), 0);
        drive(1, 0, 0, 1, 10);
        step("s_restart");
        drive(0, 0, 0, 1, 10);
        step("s_clear");
        check("s_cleared", 32'(q), 0);

        // asynchronous reset at 9
        for (int k = 0; k < 9; k++) step("r_cnt");
        check("r_at9", 32'(q), 9);
        #2 rst = 1'b0;
        #1;
        check("r_async_q", 32'(q), 0);
        check("r_async_busy", 32'(busy), 0);
        check("r_async_tc", 32'(tc), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step("r_idle");
            check("r_quiet", 32'(busy), 0);
        end

        // modulus 1, then config change while busy
        drive(1, 0, 0, 1, 1);
        step("m_start");
        drive(0, 0, 0, 1, 3);
        step("m_clear");
        for (int k = 0; k < 4; k++) begin
            step("m_run");
            check("m1_q", 32'(q), 0);
            check("m1_tc", 32'(tc), 1);
        end
        drive(0, 1, 0, 1, 3);
        step("m_stop");

        // random traffic
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 5) == 0, 1'($urandom),
                  int'($urandom_range(0, (1 << W) - 1)));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tff_counter_ctrl.md
# tff_counter_ctrl

Sequencing controller for a bank of T flip-flops that together form a programmable modulo up/down counter. The block owns a WIDTH-bit T flip-flop bank and computes, every cycle, the toggle vector that moves the bank to its next count. A start/hold/stop state machine drives the sequence, and the block flags wrap-around with a terminal-count pulse. It is the counting/timing resource shared by the term-project datapath.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled at the clock edge; begins a count sequence from IDLE.
- stop  in  1  level; returns to IDLE from CLEAR, RUN or PAUSE.
- hold  in  1  level; freezes counting while high in RUN or PAUSE.
- up  in  1  direction; latched at start (1 = up, 0 = down).
- modulus  in  WIDTH  count modulus, latched at start; 0 means 2^WIDTH.
- q  out  WIDTH  counter value, taken directly from the T flip-flop bank.
- busy  out  1  high in CLEAR, RUN and PAUSE.
- tc  out  1  one-cycle registered pulse on each wrap.

## Operation
- **States.** IDLE, CLEAR, RUN, PAUSE; 2-bit state register.
- **IDLE.**
  - Toggle vector is 0, so q holds.
  - start=1 and stop=0: latch up into dir_r and modulus into mod_r, then go to CLEAR.
- **CLEAR.**
  - Toggle = q ^ init, where init = 0 if dir_r=1, else mod_r-1 (all ones when mod_r=0).
  - Next state: RUN, or IDLE if stop=1.
- **RUN.**
  - Up count: t[0]=1 and t[i]=&q[i-1:0].
  - Down count: t[0]=1 and t[i]=&(~q[i-1:0]).
  - Wrap when q = last, where last = mod_r-1 going up and last = 0 going down:
    - Up wrap: toggle = q, so q becomes 0.
    - Down wrap: toggle = q ^ (mod_r-1).
    - Either wrap sets tc on the same edge.
  - With mod_r=0 the natural binary roll-over is the wrap.
  - hold=1 sends the block to PAUSE; the toggle vector is 0 on that edge.
  - stop=1 sends the block to IDLE with toggle 0, so q freezes at its current value.
- **PAUSE.**
  - Toggle vector is 0.
  - Next state: RUN when hold=0; IDLE when stop=1.
- **Priority.** stop > hold > count. start is ignored outside IDLE.
- **mod_r=1.** q stays 0 and tc pulses every RUN cycle.
- **Out-of-range q.** This can only arise from corruption, i.e. q ≥ mod_r while counting up. The counter still counts up to the binary roll-over and is not forced back into range. No wrap happens before the roll-over.
- **Reset (rst=0, asynchronous).**
  - q = 0, state = IDLE, busy = 0, tc = 0, dir_r = 1, mod_r = 0.
  - Reset mid-sequence aborts it immediately.
- **Output registers.** busy and tc are registered.

## Timing
- start sampled high at edge n: CLEAR after n; q = init after n+1; first count step at n+2.
- busy rises after edge n and falls on the edge that enters IDLE.
- tc is high for exactly the cycle after the wrapping edge.
- Wrapping edge means q goes from last to the wrap target on that same edge.
- hold asserted at edge k: q at k+1 equals q at k. Counting resumes on the first edge at which hold=0 is sampled in PAUSE, plus one edge for the PAUSE-to-RUN step.
- Latency from hold deassertion to the next q change: 2 edges.
- Changes on modulus or up while busy have no effect.

## Structure
- **Shared package** `tff_ctrl_pkg`:
  - state enum: IDLE=2'b00, CLEAR=2'b01, RUN=2'b10, PAUSE=2'b11.
  - `MAX_WIDTH`=16.
- **Sub-module** `tff_cell`:
  - Ports: clk, rst (async active-low, clears to 0), t, q, q_bar.
  - Instantiated WIDTH times via generate.
- **Controller.** Contains the FSM, the latched config, the combinational toggle-vector generator and the tc/busy registers.

## Test plan
1. **Up count, modulus 6.** WIDTH=4, modulus=6, up=1, pulse start → q reads 0,1,2,3,4,5,0,…; tc high the cycle after each 5→0 edge; busy=1 throughout.
2. **Down count, full range.** modulus=0, up=0, start → q reads 15,14,…,0,15; tc pulses once per 16 counts, after the 0→15 edge.
3. **Hold.** Running up with modulus=10; hold high at q=7 for 3 cycles → q stays 7 for 4 cycles (3 cycles plus the resume edge), then 8; no tc.
4. **Stop versus start/hold.** stop, start and hold all high together in RUN at q=4 → IDLE next edge, q frozen at 4, busy=0; a later start with up=1 clears q to 0 via CLEAR.
5. **Async reset.** rst low mid-cycle while q=9 in RUN → q=0, busy=0, tc=0 before the next clk edge; no activity until a new start after rst returns high.
6. **Modulus 1 and config changes.** modulus=1, start → q stays 0 and tc is high every RUN cycle; changing modulus to 3 while busy has no effect.
